bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that turns an unsigned binary result into four BCD digits for the seven-segment multiplexer. It sits between a binary arithmetic core (e.g. the Fibonacci engine) and `seven_seg_mux`, and uses the same `i_start` / `o_ready` / `o_done_tick` handshake as the rest of the sequential-logic library. Output digits are held registers, so the display never shows partial results during a conversion.

## Interface

Parameters:
- `BIN_W`, 14: width of the binary input. Legal range is 4..20. The output is always 4 digits.

Ports:
- `i_clk`, in, 1: single clock for all logic.
- `i_reset_n`, in, 1: asynchronous, active-low reset.
- `i_start`, in, 1: conversion request, sampled only while `o_ready` = 1.
- `i_bin`, in, BIN_W: unsigned binary value, captured on the accepting edge.
- `o_ready`, out, 1: high only in the IDLE state.
- `o_done_tick`, out, 1: one-cycle pulse that marks a valid new result.
- `o_bcd3`, `o_bcd2`, `o_bcd1`, `o_bcd0`, out, 4 each: held result digits (thousands down to units).
- `o_overflow`, out, 1: input exceeded 9999. Held with the digits.

## Operation

- FSM states are IDLE, OP and DONE.
- **IDLE:**
  - `o_ready` = 1.
  - If `i_start` = 1: load a shift register from `i_bin`, clear the working BCD digits, load the bit counter with BIN_W, and go to OP.
  - If `i_start` = 0, stay in IDLE.
- **OP, one step per cycle:**
  - For each working digit that is ≥ 5, add 3.
  - Shift {digits, binary register} left by one bit.
  - Decrement the counter.
  - After the BIN_W-th shift, go to DONE and copy the final digits (and overflow flag) into the output registers on the same edge.
- **DONE:**
  - `o_done_tick` = 1 and `o_ready` = 0.
  - Return to IDLE unconditionally on the next edge.
- Arithmetic rules:
  - The working digits are 4×4 bits.
  - A carry out of the thousands digit is discarded, so without saturation the result is `i_bin` mod 10000.
  - The counter is $clog2(BIN_W+1) bits wide.
- Boundary conditions:
  - `i_start` asserted in OP or DONE is ignored. It is not queued.
  - `i_bin` changes after the accepting edge have no effect.
  - `i_start` held high across DONE→IDLE starts a new conversion on the first IDLE edge (back-to-back operation).
  - Output registers change only on the edge entering DONE.
  - An input of 0 produces 0000 after the full BIN_W cycles. There is no early exit.
- **Reset:** asynchronous assertion at any time, including mid-OP, forces:
  - state to IDLE and `o_ready` = 1,
  - `o_done_tick` = 0 and `o_overflow` = 0,
  - all `o_bcd*` = 0,
  - the working registers cleared.

## Timing

- The accepting edge is k, where `i_start` = 1 and the FSM is in IDLE.
- Shifts happen on edges k+1 … k+BIN_W.
- `o_done_tick` is high from edge k+BIN_W to edge k+BIN_W+1. With BIN_W = 14, that is 14 cycles after acceptance.
- `o_bcd*` and `o_overflow` are valid starting at the same edge that raises `o_done_tick`.
- `o_ready` rises at edge k+BIN_W+1.
- Maximum throughput is one conversion per BIN_W+2 cycles.
- All outputs are registered, with no combinational input-to-output paths.

## Configuration

- Macro: `BIN2BCD_SATURATE_EN`.
- **Defined:**
  - The captured `i_bin` is compared against 9999 in IDLE.
  - If it is greater, the result registers load 9,9,9,9 at DONE and `o_overflow` is set to 1.
  - Otherwise `o_overflow` is 0.
  - The timing is identical in both cases.
- **Undefined:**
  - The compare logic is removed and `o_overflow` is tied to 0.
  - Digits equal `i_bin` mod 10000.
- The macro has no effect when BIN_W ≤ 13, because the input can never exceed 9999. `o_overflow` is still produced and is always 0.

## Structure

- Package `bin2bcd_pkg` holds:
  - the state typedef `bin2bcd_state_t` {IDLE, OP, DONE},
  - `BCD_DIGITS` = 4,
  - `BCD_MAX` = 9999.
- Sub-module `bcd_adj3`: 4-bit in, 4-bit out, adds 3 when the input is ≥ 5. It is instantiated once per digit with generate.
- The FSM, counter, shift register and output registers live in `bin2bcd_seq`.

## Test plan

- Reset, then `i_bin` = 0 with a start pulse → `o_done_tick` 14 cycles later, digits 0,0,0,0, `o_overflow` = 0.
- `i_bin` = 6765 → digits 6,7,6,5. `o_done_tick` lasts exactly 1 cycle and `o_ready` returns high on the following edge. Digits hold until the next conversion.
- `i_bin` = 12345:
  - with `BIN2BCD_SATURATE_EN` → 9,9,9,9 and `o_overflow` = 1,
  - without it → 2,3,4,5 and `o_overflow` = 0.
- Start with `i_bin` = 1234. Assert start again with `i_bin` = 9 at cycles 3 and 14 (during OP and during DONE). Expected: result 1,2,3,4, with exactly one done pulse.
- Hold `i_start` high continuously with `i_bin` = 9999 → done pulses every 16 cycles, digits 9,9,9,9.
- Previous result 6765 held; start 4181 and pull `i_reset_n` low at cycle 7. Expected, immediately and asynchronously: `o_bcd*` = 0, `o_ready` = 1, no done pulse. After release, a new start with 4181 gives 4,1,8,1.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } bin2bcd_state_t;

  // Number of BCD digits produced (thousands down to units).
  localparam int BCD_DIGITS = 4;

  // Largest value representable in four BCD digits.
  localparam int unsigned BCD_MAX = 9999;

endpackage

// File: rtl/bin2bcd_seq_bcd_adj3.sv
// Single-digit correction for the shift-and-add-3 algorithm: a digit of 5 or
// more would exceed 9 after the next left shift, so it is pre-biased by 3.
module bcd_adj3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Add 3 when the digit is 5..15; otherwise pass through unchanged.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock.
// Optional feature macro: BIN2BCD_SATURATE_EN -- inputs above 9999 produce
// 9,9,9,9 with o_overflow set; without it the result is i_bin mod 10000 and
// o_overflow is constant 0.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [BIN_W-1:0] i_bin,
  output logic             o_ready,
  output logic             o_done_tick,
  output logic [3:0]       o_bcd3,
  output logic [3:0]       o_bcd2,
  output logic [3:0]       o_bcd1,
  output logic [3:0]       o_bcd0,
  output logic             o_overflow
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  bin2bcd_state_t state_q, state_d;

  logic [BIN_W-1:0] bin_q, bin_d;   // binary bits still to be shifted in
  logic [BCD_W-1:0] bcd_q, bcd_d;   // working digits
  logic [CNT_W-1:0] cnt_q, cnt_d;   // shifts remaining
  logic [BCD_W-1:0] out_q, out_d;   // held, displayed digits
  logic [BCD_W-1:0] adj_w;          // working digits after add-3 correction
  logic [BCD_W-1:0] final_w;        // digits after the last shift
  logic             accept_w;       // start accepted on this edge
  logic             load_out_w;     // last shift happens on this edge
  logic             sat_sel_w;      // current conversion saturates

  assign accept_w   = (state_q == IDLE) && i_start;
  assign load_out_w = (state_q == OP) && (cnt_q == CNT_ONE);
  assign final_w    = {adj_w[BCD_W-2:0], bin_q[BIN_W-1]};

  // One add-3 corrector per working digit.
  for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
    bcd_adj3 u_adj (
      .digit_i (bcd_q[4*gi +: 4]),
      .digit_o (adj_w[4*gi +: 4])
    );
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: starts are only honoured in IDLE, DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_start) state_d = OP;
      OP:      if (cnt_q == CNT_ONE) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    o_ready     = (state_q == IDLE);
    o_done_tick = (state_q == DONE);
  end

  // Datapath next-state: capture, shift-and-add-3 step, and result publish.
  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    out_d = out_q;
    if (accept_w) begin
      bin_d = i_bin;
      bcd_d = '0;
      cnt_d = CNT_LOAD;
    end else if (state_q == OP) begin
      // Carry out of the thousands digit falls off the top (mod 10000).
      {bcd_d, bin_d} = {adj_w[BCD_W-2:0], bin_q, 1'b0};
      cnt_d = cnt_q - CNT_ONE;
      if (load_out_w) begin
        out_d = sat_sel_w ? {BCD_DIGITS{4'd9}} : final_w;
      end
    end
  end

  // Datapath registers; output digits only move on the edge entering DONE.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

`ifdef BIN2BCD_SATURATE_EN
  logic sat_q, sat_d;
  logic ovf_q, ovf_d;

  // Range check is made once on the captured value and published with digits.
  always_comb begin
    sat_d = sat_q;
    ovf_d = ovf_q;
    if (accept_w) begin
      sat_d = (32'(i_bin) > BCD_MAX);
    end
    if (load_out_w) begin
      ovf_d = sat_q;
    end
  end

  // Saturation flag registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
      ovf_q <= ovf_d;
    end
  end

  assign sat_sel_w  = sat_q;
  assign o_overflow = ovf_q;
`else
  assign sat_sel_w  = 1'b0;
  assign o_overflow = 1'b0;
`endif

  assign o_bcd3 = out_q[15:12];
  assign o_bcd2 = out_q[11:8];
  assign o_bcd1 = out_q[7:4];
  assign o_bcd0 = out_q[3:0];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq (BIN_W = 14).
module tb_bin2bcd_seq;

  localparam int BIN_W = 14;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b1;
  logic             start   = 1'b0;
  logic [BIN_W-1:0] bin     = '0;
  logic             ready, done, ovf;
  logic [3:0]       d3, d2, d1, d0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int bin;
    int e3, e2, e1, e0;
    int eo;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(BIN_W)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_start     (start),
    .i_bin       (bin),
    .o_ready     (ready),
    .o_done_tick (done),
    .o_bcd3      (d3),
    .o_bcd2      (d2),
    .o_bcd1      (d1),
    .o_bcd0      (d0),
    .o_overflow  (ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: the displayed number as plain arithmetic on the input value.
  function automatic void model(input int v, output int num, output int of);
    num = v % 10000;
    of  = 0;
`ifdef BIN2BCD_SATURATE_EN
    if (v > 9999) begin
      num = 9999;
      of  = 1;
    end
`endif
  endfunction

  task automatic chk_digits(input string tag, input int e3, input int e2,
                            input int e1, input int e0, input int eo);
    chk({tag, "_d3"}, 32'(d3), 32'(e3));
    chk({tag, "_d2"}, 32'(d2), 32'(e2));
    chk({tag, "_d1"}, 32'(d1), 32'(e1));
    chk({tag, "_d0"}, 32'(d0), 32'(e0));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  // One full conversion from IDLE; returns in IDLE after the done pulse.
  task automatic run_conv(input int v, input int e3, input int e2, input int e1,
                          input int e0, input int eo, input string tag);
    int lat;
    @(negedge clk);
    start = 1'b1;
    bin   = BIN_W'(v);
    @(negedge clk);                 // just after the accepting edge
    start = 1'b0;
    bin   = ~BIN_W'(v);             // must not disturb the conversion
    chk({tag, "_busy"}, 32'(ready), 32'd0);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(BIN_W));
    chk({tag, "_ready_in_done"}, 32'(ready), 32'd0);
    chk_digits(tag, e3, e2, e1, e0, eo);
    $display("conv %s: in=%0d out=%0d%0d%0d%0d ovf=%0d latency=%0d", tag, v, d3, d2, d1, d0, ovf, lat);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
    chk({tag, "_ready_back"}, 32'(ready), 32'd1);
    chk_digits({tag, "_hold"}, e3, e2, e1, e0, eo);
  endtask

  initial begin
    int pulses;
    int last_pos;
    int num, of;
    int v;

    // Reset state.
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk_digits("rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Table-driven vectors with hand-derived expectations.
    tbl.push_back('{0,     0, 0, 0, 0, 0});
    tbl.push_back('{6765,  6, 7, 6, 5, 0});
`ifdef BIN2BCD_SATURATE_EN
    tbl.push_back('{12345, 9, 9, 9, 9, 1});
    tbl.push_back('{10000, 9, 9, 9, 9, 1});
    tbl.push_back('{16383, 9, 9, 9, 9, 1});
`else
    tbl.push_back('{12345, 2, 3, 4, 5, 0});
    tbl.push_back('{10000, 0, 0, 0, 0, 0});
    tbl.push_back('{16383, 6, 3, 8, 3, 0});
`endif
    tbl.push_back('{9999,  9, 9, 9, 9, 0});
    tbl.push_back('{1,     0, 0, 0, 1, 0});
    tbl.push_back('{1000,  1, 0, 0, 0, 0});
    tbl.push_back('{5555,  5, 5, 5, 5, 0});
    tbl.push_back('{8088,  8, 0, 8, 8, 0});
    foreach (tbl[i]) begin
      run_conv(tbl[i].bin, tbl[i].e3, tbl[i].e2, tbl[i].e1, tbl[i].e0, tbl[i].eo,
               $sformatf("tbl%0d", i));
    end

    // Random values against the arithmetic model.
    for (int i = 0; i < 20; i++) begin
      v = int'($urandom_range(0, (1 << BIN_W) - 1));
      model(v, num, of);
      run_conv(v, (num / 1000) % 10, (num / 100) % 10, (num / 10) % 10, num % 10, of,
               $sformatf("rnd%0d", i));
    end

    // Starts during OP and during DONE are ignored.
    @(negedge clk);
    start = 1'b1;
    bin   = BIN_W'(1234);
    @(negedge clk);
    start  = 1'b0;
    bin    = BIN_W'(9);
    pulses = 0;
    for (int j = 0; j < 40; j++) begin
      if (done) pulses++;
      start = (j == 2 || j == 14);
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign_pulses", 32'(pulses), 32'd1);
    chk("ign_ready", 32'(ready), 32'd1);
    chk_digits("ign", 1, 2, 3, 4, 0);
    $display("ignored-start: pulses=%0d out=%0d%0d%0d%0d", pulses, d3, d2, d1, d0);

    // Back-to-back with start held high.
    @(negedge clk);
    start    = 1'b1;
    bin      = BIN_W'(9999);
    pulses   = 0;
    last_pos = -1;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (last_pos >= 0) chk("b2b_period", 32'(j - last_pos), 32'd16);
        last_pos = j;
        chk_digits("b2b", 9, 9, 9, 9, 0);
        $display("b2b pulse at cycle %0d out=%0d%0d%0d%0d", j, d3, d2, d1, d0);
      end
    end
    chk("b2b_pulses", 32'(pulses), 32'd3);
    start = 1'b0;
    repeat (20) @(negedge clk);

    // Asynchronous reset in the middle of a conversion.
    run_conv(6765, 6, 7, 6, 5, 0, "pre_rst");
    @(negedge clk);
    start = 1'b1;
    bin   = BIN_W'(4181);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_done", 32'(done), 32'd0);
    chk_digits("arst", 0, 0, 0, 0, 0);
    $display("async reset mid-OP: ready=%0d out=%0d%0d%0d%0d", ready, d3, d2, d1, d0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("arst_no_done", 32'(pulses), 32'd0);
    chk("arst_idle", 32'(ready), 32'd1);
    run_conv(4181, 4, 1, 8, 1, 0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
